parity_tx: RTL and testbench

PARITY_TX -- requirements
Module: parity_tx

---
 rtl/parity_tx.sv | 145 ++++++++++++++
 tb/tb_parity_tx.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/parity_tx.sv
// Serial parity transmitter: shifts a DATA_W-bit payload out LSB first, then a
// parity bit (even when mode=1, odd when mode=0), then a one-cycle done pulse.
module parity_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mode,
  output logic              data_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [3:0]        counter
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(DATA_W - 1);

  // Even mode sends the running XOR as-is; odd mode sends its complement.
  function automatic logic parity_bit(input logic acc, input logic even_mode);
    return acc ^ ~even_mode;
  endfunction

  logic [1:0]        state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic              acc_r, acc_s;
  logic              mode_r, mode_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              data_out_r, data_out_s;
  logic              valid_r, valid_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;

  // Next-state and datapath update for the frame sequencer.
  always_comb begin
    state_s = state_r;
    shift_s = shift_r;
    acc_s   = acc_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = 4'd0;
        if (start) begin
          state_s = ST_DATA;
          shift_s = data_in;
          mode_s  = mode;
          acc_s   = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DATA: begin
        shift_s = shift_r >> 1;
        acc_s   = acc_r ^ shift_r[0];
        cnt_s   = cnt_r + 4'd1;
        if (cnt_r == LAST_IDX) begin
          state_s = ST_PARITY;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        state_s = ST_DONE;
        cnt_s   = cnt_r + 4'd1;
      end
      ST_DONE: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Output values decoded from the upcoming state so outputs can be registered.
  always_comb begin
    data_out_s = 1'b0;
    valid_s    = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_DATA: begin
        data_out_s = shift_s[0];
        valid_s    = 1'b1;
        busy_s     = 1'b1;
      end
      ST_PARITY: begin
        data_out_s = parity_bit(acc_s, mode_s);
        valid_s    = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        done_s = 1'b1;
        busy_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      acc_r      <= 1'b0;
      mode_r     <= 1'b1;
      cnt_r      <= 4'd0;
      data_out_r <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      acc_r      <= acc_s;
      mode_r     <= mode_s;
      cnt_r      <= cnt_s;
      data_out_r <= data_out_s;
      valid_r    <= valid_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign data_out = data_out_r;
  assign valid    = valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign counter  = cnt_r;

endmodule

// File: tb/tb_parity_tx.sv
// Directed self-checking bench for parity_tx (DATA_W=8) with a parity-checking
// loopback model over 100 back-to-back frames.
module tb_parity_tx;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic       mode;
  logic       data_out;
  logic       valid;
  logic       busy;
  logic       done;
  logic [3:0] counter;

  int n_checks = 0;
  int n_fail   = 0;

  parity_tx #(.DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .mode     (mode),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .counter  (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one frame from an IDLE negedge and check every cycle through return to IDLE.
  task automatic run_frame(input logic [7:0] d, input logic m, input logic exp_par, input bit disturb);
    start   = 1'b1;
    data_in = d;
    mode    = m;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("data_bit", {31'd0, data_out}, {31'd0, d[i]});
      check("data_valid", {31'd0, valid}, 32'd1);
      check("data_busy", {31'd0, busy}, 32'd1);
      check("data_counter", {28'd0, counter}, i);
      if (disturb && i == 3) begin
        start   = 1'b1;
        data_in = ~d;
        mode    = ~m;
      end
      if (disturb && i == 4) start = 1'b0;
      @(negedge clk);
    end
    check("parity_bit", {31'd0, data_out}, {31'd0, exp_par});
    check("parity_valid", {31'd0, valid}, 32'd1);
    check("parity_counter", {28'd0, counter}, 32'd8);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("done_valid", {31'd0, valid}, 32'd0);
    check("done_data_out", {31'd0, data_out}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd1);
    check("done_counter", {28'd0, counter}, 32'd9);
    @(negedge clk);
    check("idle_done", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_valid", {31'd0, valid}, 32'd0);
    check("idle_counter", {28'd0, counter}, 32'd0);
  endtask

  initial begin
    int         frames;
    int         cyc;
    int         last_done;
    int         nb;
    bit         saw_done;
    logic [8:0] rx;
    logic [7:0] cur_d;
    logic       cur_m;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    mode    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data_out", {31'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_counter", {28'd0, counter}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(8'h0D, 1'b1, 1'b1, 1'b0);
    run_frame(8'h0D, 1'b0, 1'b0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b0, 1'b0);
    run_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    run_frame(8'h0D, 1'b1, 1'b1, 1'b1);

    // Abort a frame with reset at counter 5.
    start   = 1'b1;
    data_in = 8'hA5;
    mode    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_abort_counter", {28'd0, counter}, 32'd5);
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_counter", {28'd0, counter}, 32'd0);
    check("abort_data_out", {31'd0, data_out}, 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    run_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    run_frame(8'hA5, 1'b0, 1'b1, 1'b0);

    // Loopback: start held high, payload refreshed after each done.
    frames    = 0;
    cyc       = 0;
    last_done = -1;
    nb        = 0;
    rx        = 9'd0;
    cur_d     = 8'($urandom);
    cur_m     = 1'b1;
    data_in   = cur_d;
    mode      = cur_m;
    start     = 1'b1;
    for (int c = 0; c < 1300 && frames < 100; c++) begin
      @(negedge clk);
      cyc++;
      if (valid) begin
        if (nb < 9) rx[nb] = data_out;
        nb++;
      end
      if (done) begin
        check("loop_len", nb, 32'd9);
        check("loop_data", {24'd0, rx[7:0]}, {24'd0, cur_d});
        check("loop_parity_ok", {31'd0, ^rx}, {31'd0, ~cur_m});
        if (last_done >= 0) check("loop_spacing", cyc - last_done, 32'd11);
        last_done = cyc;
        frames++;
        nb      = 0;
        rx      = 9'd0;
        cur_d   = 8'($urandom);
        cur_m   = (frames < 50) ? 1'b1 : 1'b0;
        data_in = cur_d;
        mode    = cur_m;
        if (frames == 100) start = 1'b0;
      end
    end
    start = 1'b0;
    check("loop_frames", frames, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
